// File: rtl/seven_segment_reader.sv
// Reads a multi-digit seven-segment display bus, waits for a settled frame,
// decodes it to BCD and checks that the displayed count advances by one.
module seven_segment_reader #(
    parameter int NUM           = 6,
    parameter int CLOCK_HZ      = 50000000,
    parameter int COUNT_RATE_HZ = 10,
    parameter int STABLE_CYCLES = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [NUM-1:0][7:0] seven_segment,
    input  logic                clear_errors,
    output logic [NUM-1:0][3:0] value,
    output logic                update,
    output logic                locked,
    output logic                stalled,
    output logic                pattern_error,
    output logic                step_error,
    output logic [15:0]         update_count
);
    localparam int STALL_CYCLES = 2 * (CLOCK_HZ / COUNT_RATE_HZ);
    localparam int WD_W         = (STALL_CYCLES > 2) ? $clog2(STALL_CYCLES) : 1;
    localparam int SC_W         = $clog2(STABLE_CYCLES + 1);

    // Watchdog value one short of the stall threshold: the next count stalls.
    localparam logic [WD_W-1:0] WD_PRE_STALL = WD_W'(STALL_CYCLES - 2);
    localparam logic [SC_W-1:0] SC_ACCEPT    = SC_W'(STABLE_CYCLES - 1);
    localparam logic [SC_W-1:0] SC_DONE      = SC_W'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_LOCKED  = 2'd1,
        ST_STALLED = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [NUM-1:0][7:0]  sample;
    logic [NUM-1:0][7:0]  prev_sample;
    logic [SC_W-1:0]      stable_cnt;
    logic [WD_W-1:0]      watchdog;
    logic [WD_W-1:0]      watchdog_next;

    logic [NUM-1:0][3:0]  decoded;
    logic                 frame_valid;
    logic [NUM-1:0][3:0]  incremented;
    logic                 carry;
    logic                 accept;
    logic                 load;
    logic                 bad_frame;
    logic                 bad_step;

    always_comb begin
        frame_valid = 1'b1;
        decoded     = '0;
        for (int i = 0; i < NUM; i++) begin
            case (sample[i][6:0])
                7'h40:   decoded[i] = 4'd0;
                7'h79:   decoded[i] = 4'd1;
                7'h24:   decoded[i] = 4'd2;
                7'h30:   decoded[i] = 4'd3;
                7'h19:   decoded[i] = 4'd4;
                7'h12:   decoded[i] = 4'd5;
                7'h02:   decoded[i] = 4'd6;
                7'h78:   decoded[i] = 4'd7;
                7'h00:   decoded[i] = 4'd8;
                7'h10:   decoded[i] = 4'd9;
                default: frame_valid = 1'b0;
            endcase
        end
    end

    // BCD successor of the current value; all nines ripple to all zeros.
    always_comb begin
        carry       = 1'b1;
        incremented = value;
        for (int i = 0; i < NUM; i++) begin
            if (carry) begin
                if (value[i] == 4'd9) begin
                    incremented[i] = 4'd0;
                end else begin
                    incremented[i] = value[i] + 4'd1;
                    carry          = 1'b0;
                end
            end
        end
    end

    assign accept    = (sample == prev_sample) && (stable_cnt == SC_ACCEPT);
    assign bad_frame = accept && !frame_valid;
    assign load      = accept && frame_valid && ((state == ST_ACQUIRE) || (decoded != value));
    assign bad_step  = load && (state != ST_ACQUIRE) && (decoded != incremented);

    always_comb begin
        state_next    = state;
        watchdog_next = watchdog;
        case (state)
            ST_ACQUIRE: begin
                watchdog_next = '0;
                if (load) state_next = ST_LOCKED;
            end
            ST_LOCKED: begin
                if (load) begin
                    watchdog_next = '0;
                end else begin
                    watchdog_next = watchdog + WD_W'(1);
                    if (watchdog == WD_PRE_STALL) state_next = ST_STALLED;
                end
            end
            ST_STALLED: begin
                if (load) begin
                    watchdog_next = '0;
                    state_next    = ST_LOCKED;
                end
            end
            default: begin
                state_next    = ST_ACQUIRE;
                watchdog_next = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_ACQUIRE;
            watchdog <= '0;
        end else begin
            state    <= state_next;
            watchdog <= watchdog_next;
        end
    end

    // Reset loads a blank display so the first real frame always looks like a change.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sample      <= '1;
            prev_sample <= '1;
            stable_cnt  <= '0;
        end else begin
            sample      <= seven_segment;
            prev_sample <= sample;
            if (sample != prev_sample) begin
                stable_cnt <= '0;
            end else if (stable_cnt != SC_DONE) begin
                stable_cnt <= stable_cnt + SC_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            value         <= '0;
            update        <= 1'b0;
            update_count  <= '0;
            pattern_error <= 1'b0;
            step_error    <= 1'b0;
        end else begin
            update        <= load;
            pattern_error <= (pattern_error && !clear_errors) || bad_frame;
            step_error    <= (step_error && !clear_errors) || bad_step;
            if (load) begin
                value        <= decoded;
                update_count <= update_count + 16'd1;
            end
        end
    end

    assign locked  = (state == ST_LOCKED);
    assign stalled = (state == ST_STALLED);

endmodule

// File: tb/tb_seven_segment_reader.sv
// Bench for seven_segment_reader: an integer-level model of the display
// reader checked every cycle, plus directed scenarios with literal expectations.
module tb_seven_segment_reader;
    localparam int NUM           = 2;
    localparam int CLOCK_HZ      = 1000;
    localparam int COUNT_RATE_HZ = 100;
    localparam int STABLE_CYCLES = 4;
    localparam int STALL_CYCLES  = 2 * (CLOCK_HZ / COUNT_RATE_HZ);
    localparam int MODULUS       = 100;

    logic                clock;
    logic                reset_n;
    logic [NUM-1:0][7:0] seven_segment;
    logic                clear_errors;
    logic [NUM-1:0][3:0] value;
    logic                update;
    logic                locked;
    logic                stalled;
    logic                pattern_error;
    logic                step_error;
    logic [15:0]         update_count;

    seven_segment_reader #(
        .NUM(NUM),
        .CLOCK_HZ(CLOCK_HZ),
        .COUNT_RATE_HZ(COUNT_RATE_HZ),
        .STABLE_CYCLES(STABLE_CYCLES)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .seven_segment(seven_segment),
        .clear_errors(clear_errors),
        .value(value),
        .update(update),
        .locked(locked),
        .stalled(stalled),
        .pattern_error(pattern_error),
        .step_error(step_error),
        .update_count(update_count)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    // ---------------- scoreboard bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- display glyph table ----------------
    logic [6:0] glyph [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    function automatic logic [NUM-1:0][7:0] make_frame(input int n, input logic dp);
        logic [NUM-1:0][7:0] f;
        int rest;
        rest = n;
        for (int i = 0; i < NUM; i++) begin
            f[i] = {dp, glyph[rest % 10]};
            rest = rest / 10;
        end
        return f;
    endfunction

    function automatic logic [NUM-1:0][3:0] to_bcd(input int n);
        logic [NUM-1:0][3:0] b;
        int rest;
        rest = n;
        for (int i = 0; i < NUM; i++) begin
            b[i] = 4'(rest % 10);
            rest = rest / 10;
        end
        return b;
    endfunction

    function automatic void read_frame(input logic [NUM-1:0][7:0] f, output bit ok, output int n);
        int scale;
        ok    = 1'b1;
        n     = 0;
        scale = 1;
        for (int i = 0; i < NUM; i++) begin
            int d;
            d = -1;
            for (int j = 0; j < 10; j++) if (f[i][6:0] == glyph[j]) d = j;
            if (d < 0) ok = 1'b0;
            else n += d * scale;
            scale *= 10;
        end
    endfunction

    // ---------------- behavioural model ----------------
    // The display count is an integer; a frame is read once it has been seen on
    // STABLE_CYCLES+1 consecutive edges, and the reading acts on the next edge.
    int                  m_value   = 0;
    bit                  m_update  = 0;
    bit                  m_locked  = 0;
    bit                  m_stalled = 0;
    bit                  m_perr    = 0;
    bit                  m_serr    = 0;
    int                  m_count   = 0;
    int                  m_since   = 0;
    logic [NUM-1:0][7:0] m_frame   = '1;
    int                  m_run     = 1;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_value   = 0;
            m_update  = 0;
            m_locked  = 0;
            m_stalled = 0;
            m_perr    = 0;
            m_serr    = 0;
            m_count   = 0;
            m_since   = 0;
            m_frame   = '1;
            m_run     = 1;
        end else begin
            bit ok;
            bit new_perr;
            bit new_serr;
            bit loaded;
            bit tracking;
            int n;
            new_perr = 0;
            new_serr = 0;
            loaded   = 0;
            n        = 0;
            tracking = m_locked || m_stalled;
            if (m_run == STABLE_CYCLES + 1) begin
                read_frame(m_frame, ok, n);
                if (!ok) begin
                    new_perr = 1;
                end else if (!tracking || n != m_value) begin
                    if (tracking && n != (m_value + 1) % MODULUS) new_serr = 1;
                    loaded = 1;
                end
            end
            if (loaded) begin
                m_value   = n;
                m_count   = (m_count + 1) % 65536;
                m_since   = 0;
                m_locked  = 1;
                m_stalled = 0;
            end else if (m_locked) begin
                m_since++;
                if (m_since >= STALL_CYCLES - 1) begin
                    m_locked  = 0;
                    m_stalled = 1;
                end
            end
            m_update = loaded;
            m_perr   = (m_perr && !clear_errors) || new_perr;
            m_serr   = (m_serr && !clear_errors) || new_serr;
            if (seven_segment == m_frame) begin
                if (m_run <= STABLE_CYCLES + 1) m_run++;
            end else begin
                m_frame = seven_segment;
                m_run   = 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        check("value",         32'(value),         32'(to_bcd(m_value)));
        check("update",        32'(update),        32'(m_update));
        check("locked",        32'(locked),        32'(m_locked));
        check("stalled",       32'(stalled),       32'(m_stalled));
        check("pattern_error", 32'(pattern_error), 32'(m_perr));
        check("step_error",    32'(step_error),    32'(m_serr));
        check("update_count",  32'(update_count),  32'(m_count));
    end

    // ---------------- driver tasks ----------------
    task automatic hold(input int n, input int cycles);
        seven_segment = make_frame(n, 1'($urandom_range(0, 1)));
        repeat (cycles) @(negedge clock);
    endtask

    task automatic pulse_clear();
        clear_errors = 1'b1;
        @(negedge clock);
        clear_errors = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        reset_n       = 1'b1;
        clear_errors  = 1'b0;
        seven_segment = make_frame(7, 1'b1);
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clock);
        check("reset_value", 32'(value), 32'h0);
        check("reset_locked", 32'(locked), 32'h0);
        check("reset_count", 32'(update_count), 32'h0);
        reset_n = 1'b1;

        // First frame "07": accepted on the sixth edge after release.
        repeat (5) @(negedge clock);
        check("first_not_yet", 32'(update), 32'h0);
        @(negedge clock);
        check("first_update", 32'(update), 32'h1);
        check("first_value", 32'(value), 32'h07);
        repeat (4) @(negedge clock);
        check("first_locked", 32'(locked), 32'h1);
        check("first_count", 32'(update_count), 32'h1);
        check("first_step", 32'(step_error), 32'h0);

        hold(8, 10);
        hold(9, 10);
        hold(10, 10);
        check("ten_value", 32'(value), 32'h10);
        check("ten_count", 32'(update_count), 32'd4);
        check("ten_step", 32'(step_error), 32'h0);

        // Skipped count: loaded anyway, flagged, then cleared.
        hold(12, 10);
        check("skip_value", 32'(value), 32'h12);
        check("skip_step", 32'(step_error), 32'h1);
        pulse_clear();
        check("skip_cleared", 32'(step_error), 32'h0);

        // Same count redrawn: no action; display then stalls.
        hold(12, 25);
        check("stall_stalled", 32'(stalled), 32'h1);
        check("stall_locked", 32'(locked), 32'h0);
        check("stall_count", 32'(update_count), 32'd5);

        hold(13, 6);
        check("resume_update", 32'(update), 32'h1);
        check("resume_stalled", 32'(stalled), 32'h0);
        check("resume_locked", 32'(locked), 32'h1);
        repeat (4) @(negedge clock);

        // Flickering units digit never settles.
        for (int i = 0; i < 10; i++) begin
            seven_segment = make_frame(11, 1'b1);
            repeat (2) @(negedge clock);
            seven_segment = make_frame(12, 1'b1);
            repeat (2) @(negedge clock);
        end
        check("flicker_count", 32'(update_count), 32'd6);
        check("flicker_value", 32'(value), 32'h13);

        seven_segment = {8'hF9, 8'h7F};
        repeat (10) @(negedge clock);
        check("blank_perr", 32'(pattern_error), 32'h1);
        check("blank_value", 32'(value), 32'h13);

        // Clear held through a new bad frame: the new error wins on its edge.
        seven_segment = {8'hF9, 8'h7E};
        clear_errors  = 1'b1;
        @(negedge clock);
        check("clear_first", 32'(pattern_error), 32'h0);
        repeat (5) @(negedge clock);
        clear_errors = 1'b0;
        check("clear_vs_new", 32'(pattern_error), 32'h1);
        repeat (4) @(negedge clock);

        hold(14, 10);
        check("after_stall_locked", 32'(locked), 32'h1);
        check("after_stall_step", 32'(step_error), 32'h0);

        for (int n = 15; n <= MODULUS; n++) hold(n % MODULUS, 10);
        check("wrap_value", 32'(value), 32'h00);
        check("wrap_step", 32'(step_error), 32'h0);
        check("wrap_count", 32'(update_count), 32'd93);

        // Reset mid-stability discards the partial frame.
        seven_segment = make_frame(1, 1'b1);
        repeat (3) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("async_value", 32'(value), 32'h0);
        check("async_perr", 32'(pattern_error), 32'h0);
        check("async_count", 32'(update_count), 32'h0);
        check("async_locked", 32'(locked), 32'h0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (5) @(negedge clock);
        check("rearm_not_yet", 32'(update), 32'h0);
        @(negedge clock);
        check("rearm_update", 32'(update), 32'h1);
        check("rearm_value", 32'(value), 32'h01);
        check("rearm_count", 32'(update_count), 32'd1);
        repeat (3) @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seven_segment_reader.md
SEVEN_SEGMENT_READER -- requirements
Module: seven_segment_reader

Interface
REQ-001 SHALL have parameter NUM, default 6: number of digits observed.
REQ-002 SHALL have parameter CLOCK_HZ, default 50000000: clock frequency.
REQ-003 SHALL have parameter COUNT_RATE_HZ, default 10: expected increment rate; STALL_CYCLES = 2*(CLOCK_HZ/COUNT_RATE_HZ).
REQ-004 SHALL have parameter STABLE_CYCLES, default 16, minimum 2: consecutive identical samples required to accept a frame.
REQ-005 clock  input  1  rising-edge clock, sole clock.
REQ-006 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-007 seven_segment  input  [NUM-1:0][7:0]  segment bus, per digit bit0=a..bit6=g, bit7=dp, active-low (0 = lit).
REQ-008 clear_errors  input  1  single-cycle pulse clearing sticky error flags.
REQ-009 value  output  [NUM-1:0][3:0]  last accepted BCD value, digit 0 least significant.
REQ-010 update  output  1  one-cycle pulse when value changes.
REQ-011 locked  output  1  high while FSM in LOCKED.
REQ-012 stalled  output  1  high while FSM in STALLED.
REQ-013 pattern_error  output  1  sticky: stable frame with an undecodable digit.
REQ-014 step_error  output  1  sticky: accepted value not previous+1.
REQ-015 update_count  output  16  number of update pulses since reset, wraps at 16'hFFFF->0.

Function
REQ-016 SHALL register seven_segment once per cycle; all decisions use the registered sample.
REQ-017 SHALL decode per digit, ignoring bit7: 7'h40=0, 79=1, 24=2, 30=3, 19=4, 12=5, 02=6, 78=7, 00=8, 10=9; any other pattern is invalid.
REQ-018 SHALL reset the stability counter to 0 whenever the registered sample differs from the previous registered sample.
REQ-019 SHALL accept a frame exactly once when the sample has been identical for STABLE_CYCLES consecutive registered samples; no re-acceptance until the sample changes.
REQ-020 On acceptance with any invalid digit: SHALL set pattern_error, leave value, update, FSM and watchdog unchanged.
REQ-021 On acceptance of a valid frame equal to value: SHALL take no action (no update, no step check).
REQ-022 On acceptance of a valid frame differing from value: SHALL load value, pulse update next edge, increment update_count, clear watchdog.
REQ-023 Step check: in LOCKED or STALLED, new value SHALL equal value+1 in NUM-digit BCD, with all-9s wrapping to all-0s; otherwise set step_error (value still loaded).
REQ-024 FSM ACQUIRE -> LOCKED on first valid accepted frame (loaded and updated regardless of equality to reset value 0; no step check).
REQ-025 FSM LOCKED -> STALLED when watchdog reaches STALL_CYCLES-1 with no update; watchdog saturates.
REQ-026 FSM STALLED -> LOCKED on next update; stalled deasserts same edge update asserts.
REQ-027 Watchdog SHALL count only in LOCKED; held at 0 in ACQUIRE.
REQ-028 clear_errors SHALL clear both sticky flags; if a new error is detected in the same cycle, that flag SHALL remain set.
REQ-029 Latency: sample constant at inputs for edges k..k+STABLE_CYCLES; value/update valid after edge k+STABLE_CYCLES+1.

Reset
REQ-030 reset_n low SHALL immediately force: value=0, update=0, locked=0, stalled=0, pattern_error=0, step_error=0, update_count=0, FSM=ACQUIRE, stability counter and watchdog=0, sample register=all ones (blank).
REQ-031 Reset mid-stability or mid-stall SHALL discard all progress; post-reset behaviour identical to power-up.

Verification (NUM=2, STABLE_CYCLES=4, CLOCK_HZ=1000, COUNT_RATE_HZ=100, STALL_CYCLES=20)
REQ-032 Drive "07" (digit1=40,digit0=78) steady after reset -> one update, value=07, locked=1, update_count=1, step_error=0.
REQ-033 Then "08", "09", "10", each held 10 cycles -> three updates, value=10, update_count=4, step_error=0; repeat through "99"->"00" -> wrap accepted, step_error=0.
REQ-034 From "10" drive "12" -> value=12, update pulses, step_error=1; clear_errors pulse -> step_error=0.
REQ-035 Toggle digit0 between 79 and 24 every 2 cycles for 40 cycles -> no update; then drive digit0=7F held -> pattern_error=1, value unchanged.
REQ-036 Hold "12" 25 cycles after update -> stalled=1, locked=0 at watchdog 19; then "13" -> update, stalled=0, locked=1.
REQ-037 Assert reset_n low during 3rd stable cycle of new frame -> all outputs zero immediately; frame not accepted until re-held STABLE_CYCLES after release.
